// File: rtl/bit_twiddle_arbiter_if.sv
// Request/result bundle for the shared bit-twiddle arbiter.
// slave: the arbiter side. master: the requester/consumer side.
interface bit_twiddle_arbiter_if #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
);
    logic          a_valid;
    logic          a_ready;
    logic [1:0]    a_op;
    logic [W-1:0]  a_data;
    logic [CW-1:0] a_cnt;

    logic          b_valid;
    logic          b_ready;
    logic [1:0]    b_op;
    logic [W-1:0]  b_data;
    logic [CW-1:0] b_cnt;

    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          res_id;
    logic          busy;

    modport slave (
        input  a_valid, a_op, a_data, a_cnt,
        input  b_valid, b_op, b_data, b_cnt,
        input  res_ready,
        output a_ready, b_ready,
        output res_valid, res_data, res_id, busy
    );

    modport master (
        output a_valid, a_op, a_data, a_cnt,
        output b_valid, b_op, b_data, b_cnt,
        output res_ready,
        input  a_ready, b_ready,
        input  res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/bit_twiddle_arbiter.sv
// Two-port arbiter and sequencer for the shared 8-bit twiddle datapath.
// Ops: 00 reverse, 01 negate, 10 rotate-right by cnt, 11 pass.
// Define BIT_TWIDDLE_RR_EN for round-robin arbitration; otherwise port A
// has fixed priority over port B.
//
// state | meaning
// IDLE  | arbitrating, ready driven to the granted port
// EXEC  | operation running (rotate steps one bit per cycle)
// DONE  | result presented, waiting for res_ready
module bit_twiddle_arbiter #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input logic clk,
    input logic rst_n,
    bit_twiddle_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [1:0]    op;
    logic [W-1:0]  acc;
    logic [CW-1:0] remaining;
    logic          id;
    logic          res_valid_q;
    logic [W-1:0]  res_data_q;
    logic          res_id_q;
    logic          busy_q;
    logic          grant_b;
    logic          accept;
    logic          exec_last;
    logic [W-1:0]  exec_res;
    logic [W-1:0]  acc_rot;

`ifdef BIT_TWIDDLE_RR_EN
    logic          last_id;
`endif

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i] = v[W-1-i];
        end
        return r;
    endfunction

    // Pick which port would be granted if the block is idle.
    always_comb begin
        grant_b = 1'b0;
`ifdef BIT_TWIDDLE_RR_EN
        grant_b = bus.b_valid && (!bus.a_valid || !last_id);
`else
        grant_b = bus.b_valid && !bus.a_valid;
`endif
    end

    assign bus.a_ready = rst_n && (state == IDLE) && bus.a_valid && !grant_b;
    assign bus.b_ready = rst_n && (state == IDLE) && grant_b;
    assign accept      = bus.a_ready || bus.b_ready;

    // Result of the current EXEC cycle and whether it is the final one.
    always_comb begin
        acc_rot   = {acc[0], acc[W-1:1]};
        exec_last = 1'b1;
        exec_res  = acc;
        case (op)
            2'b00: exec_res = bit_rev(acc);
            2'b01: exec_res = ~acc + W'(1);
            2'b10: begin
                exec_last = (remaining <= CW'(1));
                exec_res  = (remaining == '0) ? acc : acc_rot;
            end
            default: exec_res = acc;
        endcase
    end

    // Sequencer: accept, execute, hold result until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= 2'b11;
            acc         <= '0;
            remaining   <= '0;
            id          <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BIT_TWIDDLE_RR_EN
            last_id     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op        <= grant_b ? bus.b_op   : bus.a_op;
                        acc       <= grant_b ? bus.b_data : bus.a_data;
                        remaining <= grant_b ? bus.b_cnt  : bus.a_cnt;
                        id        <= grant_b;
                        busy_q    <= 1'b1;
                        state     <= EXEC;
`ifdef BIT_TWIDDLE_RR_EN
                        last_id   <= grant_b;
`endif
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        res_data_q  <= exec_res;
                        res_id_q    <= id;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        acc       <= acc_rot;
                        remaining <= remaining - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bit_twiddle_arbiter.sv
// Scoreboard bench for bit_twiddle_arbiter: directed test-plan cases then
// random traffic, checked against a transaction-level model.
// Build with BIT_TWIDDLE_RR_EN defined to check the round-robin variant.
module tb_bit_twiddle_arbiter;

    localparam int W  = 8;
    localparam int CW = 3;

    typedef struct {
        bit         v;
        logic [1:0] op;
        logic [7:0] data;
        logic [2:0] cnt;
    } req_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_twiddle_arbiter_if #(.W(W), .CW(CW)) bus ();
    bit_twiddle_arbiter #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    req_t qa[$];
    req_t qb[$];
    req_t pa, pb;
    bit   acc_a, acc_b;
    bit   outstanding = 0;
    int   due_cyc = 0;
    bit   m_last_id = 1;
    int   hold_lo = 0;
    bit   rand_on = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: the operation defined arithmetically on integers.
    function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] d, input int k);
        int v, r;
        v = int'(d);
        r = 0;
        case (op)
            2'd0: for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) r += (1 << (7 - i));
            2'd1: r = (256 - v) % 256;
            2'd2: r = ((v >> k) | (v << (8 - k))) & 255;
            default: r = v;
        endcase
        return 8'(r);
    endfunction

    function automatic int model_lat(input logic [1:0] op, input int k);
        if (op == 2'd2) return 1 + ((k > 1) ? k : 1);
        return 2;
    endfunction

    function automatic req_t mk(input logic [1:0] op, input logic [7:0] data, input logic [2:0] cnt);
        req_t r;
        r.v = 1'b1; r.op = op; r.data = data; r.cnt = cnt;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom_range(0, 7)));
    endfunction

    // One clock of stimulus plus the model's view of arbitration.
    task automatic step(input logic rst_val);
        bit ga, gb;
        req_t w;
        @(negedge clk);
        rst_n = rst_val;
        if (acc_a) pa.v = 1'b0;
        if (acc_b) pb.v = 1'b0;
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (!pa.v) begin
            if (qa.size() > 0) pa = qa.pop_front();
            else if (rand_on && $urandom_range(0, 99) < 40) pa = rand_req();
        end
        if (!pb.v) begin
            if (qb.size() > 0) pb = qb.pop_front();
            else if (rand_on && $urandom_range(0, 99) < 40) pb = rand_req();
        end
        bus.a_valid = pa.v; bus.a_op = pa.op; bus.a_data = pa.data; bus.a_cnt = pa.cnt;
        bus.b_valid = pb.v; bus.b_op = pb.op; bus.b_data = pb.data; bus.b_cnt = pb.cnt;
        if (hold_lo > 0) begin
            bus.res_ready = 1'b0;
            hold_lo--;
        end else begin
            bus.res_ready = rand_on ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (rst_n && !outstanding) begin
            if (pa.v && pb.v) begin
`ifdef BIT_TWIDDLE_RR_EN
                if (m_last_id) ga = 1'b1; else gb = 1'b1;
`else
                ga = 1'b1;
`endif
            end else if (pa.v) ga = 1'b1;
            else if (pb.v) gb = 1'b1;
        end
        check("a_ready", bus.a_ready, ga);
        check("b_ready", bus.b_ready, gb);
        check("busy", bus.busy, outstanding);
        if (!rst_n) begin
            outstanding = 1'b0;
            m_last_id = 1'b1;
            sb.delete();
        end else if (ga || gb) begin
            w = ga ? pa : pb;
            sb.push_back('{id: gb, data: model_op(w.op, w.data, int'(w.cnt)),
                           due: cyc + model_lat(w.op, int'(w.cnt))});
            outstanding = 1'b1;
            due_cyc = cyc + model_lat(w.op, int'(w.cnt));
            m_last_id = gb;
            acc_a = ga;
            acc_b = gb;
        end else if (outstanding && cyc >= due_cyc && bus.res_ready) begin
            outstanding = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((outstanding || sb.size() > 0 || pa.v || pb.v || qa.size() > 0 || qb.size() > 0) && n < 200) begin
            step(1'b1);
            n++;
        end
        check("drain_timeout", (n < 200), 1);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                if (sb.size() == 0) begin
                    check("res_valid_idle", bus.res_valid, 0);
                end else if (bus.res_valid) begin
                    if (!seen) begin
                        check("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    check("res_data", bus.res_data, sb[0].data);
                    check("res_id", bus.res_id, sb[0].id);
                    if (bus.res_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end else if (cyc >= sb[0].due) begin
                    check("res_valid_due", bus.res_valid, 1);
                end
            end
        end
    end

    initial begin
        pa = '{v: 1'b0, op: 2'b0, data: 8'h0, cnt: 3'h0};
        pb = pa;
        acc_a = 1'b0;
        acc_b = 1'b0;
        bus.a_valid = 1'b0; bus.a_op = '0; bus.a_data = '0; bus.a_cnt = '0;
        bus.b_valid = 1'b0; bus.b_op = '0; bus.b_data = '0; bus.b_cnt = '0;
        bus.res_ready = 1'b0;

        repeat (3) step(1'b0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);

        qa.push_back(mk(2'b00, 8'hB1, 3'd0));
        drain();

        qb.push_back(mk(2'b01, 8'h01, 3'd0));
        qb.push_back(mk(2'b01, 8'h80, 3'd0));
        qb.push_back(mk(2'b01, 8'h00, 3'd0));
        drain();

        qa.push_back(mk(2'b10, 8'h01, 3'd3));
        qa.push_back(mk(2'b10, 8'h01, 3'd0));
        qa.push_back(mk(2'b10, 8'h96, 3'd7));
        qa.push_back(mk(2'b10, 8'h96, 3'd1));
        drain();

        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(2'b11, 8'hAA, 3'd0));
            qb.push_back(mk(2'b11, 8'h55, 3'd0));
        end
        drain();

        // Backpressure: five DONE cycles with res_ready low, B waiting behind.
        qa.push_back(mk(2'b11, 8'h3C, 3'd0));
        qb.push_back(mk(2'b00, 8'h0F, 3'd0));
        hold_lo = 7;
        drain();

        // Reset during rotate EXEC cycle 3, then A must win a tie.
        qa.push_back(mk(2'b10, 8'h81, 3'd7));
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check("rst_mid_res_valid", bus.res_valid, 0);
        qa.push_back(mk(2'b11, 8'hC3, 3'd0));
        qb.push_back(mk(2'b11, 8'h3C, 3'd0));
        drain();

        rand_on = 1'b1;
        repeat (800) step(1'b1);
        rand_on = 1'b0;
        drain();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
